// File: rtl/rtype_control_sequencer.sv
// rtype_control_sequencer: hardwired multi-cycle control for register-to-register
// ALU instructions. Fetch runs in T0-T2 and execute in T3-T6. The mul/div class
// writes two results (LO, then HI). ir is decoded directly and must stay stable
// from T3 until the instruction finishes.
module rtype_control_sequencer #(
  parameter int NREGS   = 16,
  parameter int ALUOP_W = 4,
  parameter int CNT_W   = 16
) (
  input  logic               clock,
  input  logic               clear,
  input  logic               start,
  input  logic               mem_ready,
  input  logic [31:0]        ir,
  output logic               PCout,
  output logic               MARin,
  output logic               IncPC,
  output logic               PCin,
  output logic               Read,
  output logic               MDRin,
  output logic               MDRout,
  output logic               IRin,
  output logic               Yin,
  output logic               Zlowin,
  output logic               Zhighin,
  output logic               Zlowout,
  output logic               Zhighout,
  output logic               LOin,
  output logic               HIin,
  output logic [NREGS-1:0]   Rin,
  output logic [NREGS-1:0]   Rout,
  output logic [ALUOP_W-1:0] ALUop,
  output logic               busy,
  output logic               done,
  output logic               illegal,
  output logic [CNT_W-1:0]   instr_count
);

  typedef enum logic [2:0] {IDLE, T0, T1, T2, T3, T4, T5, T6} state_t;

  localparam logic [4:0] NREGS_L = 5'(NREGS);

  state_t     state;
  logic       t1_wait;
  logic [4:0] opcode;
  logic [3:0] ra, rb, rc;
  logic       is_single, is_dual, legal;

  assign opcode = ir[31:27];
  assign ra     = ir[26:23];
  assign rb     = ir[22:19];
  assign rc     = ir[18:15];

  // Classify the opcode and check that every register field it uses exists.
  always_comb begin
    is_single = (opcode >= 5'h03) && (opcode <= 5'h0B);
    is_dual   = (opcode == 5'h0F) || (opcode == 5'h10);
    legal     = (is_single && ({1'b0, ra} < NREGS_L) && ({1'b0, rb} < NREGS_L) &&
                 ({1'b0, rc} < NREGS_L)) ||
                (is_dual && ({1'b0, rb} < NREGS_L) && ({1'b0, rc} < NREGS_L));
  end

  // Advance the state and count retired instructions.
  // t1_wait marks memory wait cycles so the PC update fires only once.
  always_ff @(posedge clock or posedge clear) begin
    if (clear) begin
      state       <= IDLE;
      t1_wait     <= 1'b0;
      instr_count <= '0;
    end else begin
      if (done) instr_count <= instr_count + CNT_W'(1);
      case (state)
        IDLE: if (start) state <= T0;
        T0: begin
          state   <= T1;
          t1_wait <= 1'b0;
        end
        T1: begin
          if (mem_ready) begin
            state   <= T2;
            t1_wait <= 1'b0;
          end else begin
            t1_wait <= 1'b1;
          end
        end
        T2:      state <= T3;
        T3:      state <= legal ? T4 : IDLE;
        T4:      state <= T5;
        T5:      state <= is_dual ? T6 : IDLE;
        T6:      state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Moore decode of the datapath enables from the current step and ir fields.
  always_comb begin
    PCout    = 1'b0;
    MARin    = 1'b0;
    IncPC    = 1'b0;
    PCin     = 1'b0;
    Read     = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zlowin   = 1'b0;
    Zhighin  = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    LOin     = 1'b0;
    HIin     = 1'b0;
    Rin      = '0;
    Rout     = '0;
    ALUop    = '0;
    done     = 1'b0;
    illegal  = 1'b0;
    busy     = (state != IDLE);
    case (state)
      T0: begin
        PCout  = 1'b1;
        MARin  = 1'b1;
        IncPC  = 1'b1;
        Zlowin = 1'b1;
      end
      T1: begin
        Zlowout = !t1_wait;
        PCin    = !t1_wait;
        Read    = 1'b1;
        MDRin   = 1'b1;
      end
      T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
      end
      T3: begin
        if (legal) begin
          Rout = NREGS'(1) << rb;
          Yin  = 1'b1;
        end else begin
          illegal = 1'b1;
        end
      end
      T4: begin
        Rout    = NREGS'(1) << rc;
        Zlowin  = 1'b1;
        Zhighin = is_dual;
        if (opcode == 5'h0F)      ALUop = '1;
        else if (opcode == 5'h10) ALUop = {ALUOP_W{1'b1}} - ALUOP_W'(1);
        else                      ALUop = ALUOP_W'(opcode);
      end
      T5: begin
        Zlowout = 1'b1;
        if (is_dual) begin
          LOin = 1'b1;
        end else begin
          Rin  = NREGS'(1) << ra;
          done = 1'b1;
        end
      end
      T6: begin
        Zhighout = 1'b1;
        HIin     = 1'b1;
        done     = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_rtype_control_sequencer.sv
// Directed testbench for rtype_control_sequencer. Three instances share the clock,
// clear, ir and mem_ready signals: the default build, one with NREGS=8, and one
// with CNT_W=2. Each instance has its own start input.
module tb_rtype_control_sequencer;

  // Enable vector bit order: PCout MARin IncPC PCin Read MDRin MDRout IRin
  // Yin Zlowin Zhighin Zlowout Zhighout LOin HIin (bit 0 first).
  localparam logic [14:0] M_T0  = 15'h0207;
  localparam logic [14:0] M_T1F = 15'h0838;
  localparam logic [14:0] M_T1W = 15'h0030;
  localparam logic [14:0] M_T2  = 15'h00C0;
  localparam logic [14:0] M_T3  = 15'h0100;
  localparam logic [14:0] M_T4S = 15'h0200;
  localparam logic [14:0] M_T4D = 15'h0600;
  localparam logic [14:0] M_T5S = 15'h0800;
  localparam logic [14:0] M_T5D = 15'h2800;
  localparam logic [14:0] M_T6  = 15'h5000;

  localparam logic [31:0] IR_ADD  = 32'h192B0000;
  localparam logic [31:0] IR_MUL  = 32'h781A0000;
  localparam logic [31:0] IR_DIV  = 32'h80090000;
  localparam logic [31:0] IR_BAD  = 32'hF8000000;
  localparam logic [31:0] IR_RA9  = 32'h1C890000;

  logic        clock = 1'b0;
  logic        clear, start0, start1, start2, mem_ready;
  logic [31:0] ir;
  int          checks = 0;
  int          errors = 0;

  wire [14:0] en0, en1, en2;
  wire [15:0] rin0, rout0, rin2, rout2;
  wire [7:0]  rin1, rout1;
  wire [3:0]  alu0, alu1, alu2;
  wire        busy0, busy1, busy2, done0, done1, done2, ill0, ill1, ill2;
  wire [15:0] cnt0, cnt1;
  wire [1:0]  cnt2;

  always #5 clock = ~clock;

  rtype_control_sequencer dut0 (
    .clock(clock), .clear(clear), .start(start0), .mem_ready(mem_ready), .ir(ir),
    .PCout(en0[0]), .MARin(en0[1]), .IncPC(en0[2]), .PCin(en0[3]), .Read(en0[4]),
    .MDRin(en0[5]), .MDRout(en0[6]), .IRin(en0[7]), .Yin(en0[8]), .Zlowin(en0[9]),
    .Zhighin(en0[10]), .Zlowout(en0[11]), .Zhighout(en0[12]), .LOin(en0[13]), .HIin(en0[14]),
    .Rin(rin0), .Rout(rout0), .ALUop(alu0), .busy(busy0), .done(done0),
    .illegal(ill0), .instr_count(cnt0)
  );

  rtype_control_sequencer #(.NREGS(8)) dut1 (
    .clock(clock), .clear(clear), .start(start1), .mem_ready(mem_ready), .ir(ir),
    .PCout(en1[0]), .MARin(en1[1]), .IncPC(en1[2]), .PCin(en1[3]), .Read(en1[4]),
    .MDRin(en1[5]), .MDRout(en1[6]), .IRin(en1[7]), .Yin(en1[8]), .Zlowin(en1[9]),
    .Zhighin(en1[10]), .Zlowout(en1[11]), .Zhighout(en1[12]), .LOin(en1[13]), .HIin(en1[14]),
    .Rin(rin1), .Rout(rout1), .ALUop(alu1), .busy(busy1), .done(done1),
    .illegal(ill1), .instr_count(cnt1)
  );

  rtype_control_sequencer #(.CNT_W(2)) dut2 (
    .clock(clock), .clear(clear), .start(start2), .mem_ready(mem_ready), .ir(ir),
    .PCout(en2[0]), .MARin(en2[1]), .IncPC(en2[2]), .PCin(en2[3]), .Read(en2[4]),
    .MDRin(en2[5]), .MDRout(en2[6]), .IRin(en2[7]), .Yin(en2[8]), .Zlowin(en2[9]),
    .Zhighin(en2[10]), .Zlowout(en2[11]), .Zhighout(en2[12]), .LOin(en2[13]), .HIin(en2[14]),
    .Rin(rin2), .Rout(rout2), .ALUop(alu2), .busy(busy2), .done(done2),
    .illegal(ill2), .instr_count(cnt2)
  );

  // Reset state with clear asserted at time zero.
  task automatic test_reset;
    clear = 1'b1; start0 = 1'b0; start1 = 1'b0; start2 = 1'b0;
    mem_ready = 1'b1; ir = IR_ADD;
    #1;
    checks++; if (en0 !== 15'h0) begin errors++; $display("[TB] FAIL reset_en got %h exp 0", en0); end
    checks++; if ({rin0, rout0, alu0} !== 36'h0) begin errors++; $display("[TB] FAIL reset_regs got %h exp 0", {rin0, rout0, alu0}); end
    checks++; if ({busy0, done0, ill0} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags got %b exp 000", {busy0, done0, ill0}); end
    checks++; if (cnt0 !== 16'd0) begin errors++; $display("[TB] FAIL reset_count got %0d exp 0", cnt0); end
    @(negedge clock);
    @(negedge clock);
    clear = 1'b0;
  endtask

  // ADD R2,R5,R6 with memory ready in the first T1 cycle.
  task automatic test_add;
    ir = IR_ADD; mem_ready = 1'b1;
    start0 = 1'b1;
    @(negedge clock); start0 = 1'b0;
    checks++; if (en0 !== M_T0 || busy0 !== 1'b1) begin errors++; $display("[TB] FAIL add_t0 got %h/%b exp %h/1", en0, busy0, M_T0); end
    @(negedge clock);
    checks++; if (en0 !== M_T1F) begin errors++; $display("[TB] FAIL add_t1 got %h exp %h", en0, M_T1F); end
    @(negedge clock);
    checks++; if (en0 !== M_T2) begin errors++; $display("[TB] FAIL add_t2 got %h exp %h", en0, M_T2); end
    @(negedge clock);
    checks++; if (en0 !== M_T3 || rout0 !== 16'h0020 || ill0 !== 1'b0) begin errors++; $display("[TB] FAIL add_t3 got en=%h rout=%h ill=%b exp en=%h rout=0020 ill=0", en0, rout0, ill0, M_T3); end
    @(negedge clock);
    checks++; if (en0 !== M_T4S || rout0 !== 16'h0040 || alu0 !== 4'h3) begin errors++; $display("[TB] FAIL add_t4 got en=%h rout=%h alu=%h exp en=%h rout=0040 alu=3", en0, rout0, alu0, M_T4S); end
    @(negedge clock);
    checks++; if (en0 !== M_T5S || rin0 !== 16'h0004 || rout0 !== 16'h0 || done0 !== 1'b1) begin errors++; $display("[TB] FAIL add_t5 got en=%h rin=%h rout=%h done=%b exp en=%h rin=0004 rout=0 done=1", en0, rin0, rout0, done0, M_T5S); end
    @(negedge clock);
    checks++; if (busy0 !== 1'b0 || done0 !== 1'b0 || cnt0 !== 16'd1) begin errors++; $display("[TB] FAIL add_end got busy=%b done=%b cnt=%0d exp 0 0 1", busy0, done0, cnt0); end
  endtask

  // Three wait cycles in T1: PC updated only in the first, done three cycles late.
  task automatic test_mem_wait;
    int cyc;
    ir = IR_ADD; mem_ready = 1'b0;
    start0 = 1'b1;
    @(negedge clock); start0 = 1'b0;
    cyc = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock); cyc++;
      checks++;
      if (en0 !== ((i == 0) ? M_T1F : M_T1W)) begin
        errors++; $display("[TB] FAIL wait_t1_%0d got %h exp %h", i, en0, (i == 0) ? M_T1F : M_T1W);
      end
      if (i == 3) mem_ready = 1'b1;
    end
    while (done0 !== 1'b1 && cyc < 20) begin
      @(negedge clock); cyc++;
    end
    checks++; if (cyc !== 9 || done0 !== 1'b1) begin errors++; $display("[TB] FAIL wait_latency got %0d done=%b exp 9 done=1", cyc, done0); end
    @(negedge clock);
    checks++; if (cnt0 !== 16'd2) begin errors++; $display("[TB] FAIL wait_count got %0d exp 2", cnt0); end
  endtask

  // MUL R3,R4 then a div: two-result class with LO then HI writeback.
  task automatic test_mul;
    ir = IR_MUL; mem_ready = 1'b1;
    start0 = 1'b1;
    @(negedge clock); start0 = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (en0 !== M_T3 || rout0 !== 16'h0008) begin errors++; $display("[TB] FAIL mul_t3 got en=%h rout=%h exp en=%h rout=0008", en0, rout0, M_T3); end
    @(negedge clock);
    checks++; if (en0 !== M_T4D || rout0 !== 16'h0010 || alu0 !== 4'hF || rin0 !== 16'h0) begin errors++; $display("[TB] FAIL mul_t4 got en=%h rout=%h alu=%h rin=%h exp en=%h rout=0010 alu=f rin=0", en0, rout0, alu0, rin0, M_T4D); end
    @(negedge clock);
    checks++; if (en0 !== M_T5D || rin0 !== 16'h0 || done0 !== 1'b0) begin errors++; $display("[TB] FAIL mul_t5 got en=%h rin=%h done=%b exp en=%h rin=0 done=0", en0, rin0, done0, M_T5D); end
    @(negedge clock);
    checks++; if (en0 !== M_T6 || rin0 !== 16'h0 || done0 !== 1'b1 || alu0 !== 4'h0) begin errors++; $display("[TB] FAIL mul_t6 got en=%h rin=%h done=%b alu=%h exp en=%h rin=0 done=1 alu=0", en0, rin0, done0, alu0, M_T6); end
    @(negedge clock);
    checks++; if (busy0 !== 1'b0 || cnt0 !== 16'd3) begin errors++; $display("[TB] FAIL mul_end got busy=%b cnt=%0d exp 0 3", busy0, cnt0); end
    ir = IR_DIV;
    start0 = 1'b1;
    @(negedge clock); start0 = 1'b0;
    repeat (4) @(negedge clock);
    checks++; if (en0 !== M_T4D || alu0 !== 4'hE || rout0 !== 16'h0004) begin errors++; $display("[TB] FAIL div_t4 got en=%h alu=%h rout=%h exp en=%h alu=e rout=0004", en0, alu0, rout0, M_T4D); end
    repeat (2) @(negedge clock);
    checks++; if (done0 !== 1'b1 || en0 !== M_T6) begin errors++; $display("[TB] FAIL div_t6 got done=%b en=%h exp 1 %h", done0, en0, M_T6); end
    @(negedge clock);
    checks++; if (cnt0 !== 16'd4) begin errors++; $display("[TB] FAIL div_count got %0d exp 4", cnt0); end
  endtask

  // Bad opcode on the default build, and Ra=9 on the NREGS=8 build.
  task automatic test_illegal;
    ir = IR_BAD; mem_ready = 1'b1;
    start0 = 1'b1;
    @(negedge clock); start0 = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (ill0 !== 1'b1 || rout0 !== 16'h0 || en0 !== 15'h0 || done0 !== 1'b0) begin errors++; $display("[TB] FAIL ill_op_t3 got ill=%b rout=%h en=%h done=%b exp 1 0 0 0", ill0, rout0, en0, done0); end
    @(negedge clock);
    checks++; if (busy0 !== 1'b0 || ill0 !== 1'b0 || done0 !== 1'b0 || cnt0 !== 16'd4) begin errors++; $display("[TB] FAIL ill_op_end got busy=%b ill=%b done=%b cnt=%0d exp 0 0 0 4", busy0, ill0, done0, cnt0); end
    ir = IR_RA9;
    start1 = 1'b1;
    @(negedge clock); start1 = 1'b0;
    repeat (3) @(negedge clock);
    checks++; if (ill1 !== 1'b1 || rout1 !== 8'h0 || en1[8] !== 1'b0) begin errors++; $display("[TB] FAIL ill_ra_t3 got ill=%b rout=%h yin=%b exp 1 0 0", ill1, rout1, en1[8]); end
    @(negedge clock);
    checks++; if (busy1 !== 1'b0 || done1 !== 1'b0 || cnt1 !== 16'd0) begin errors++; $display("[TB] FAIL ill_ra_end got busy=%b done=%b cnt=%0d exp 0 0 0", busy1, done1, cnt1); end
  endtask

  // Asynchronous clear between edges while in T4, then a normal instruction.
  task automatic test_reset_mid;
    int cyc;
    ir = IR_ADD; mem_ready = 1'b1;
    start0 = 1'b1;
    @(negedge clock); start0 = 1'b0;
    repeat (4) @(negedge clock);
    checks++; if (en0 !== M_T4S) begin errors++; $display("[TB] FAIL mid_in_t4 got %h exp %h", en0, M_T4S); end
    #2 clear = 1'b1;
    #1;
    checks++; if (en0 !== 15'h0 || rout0 !== 16'h0 || alu0 !== 4'h0 || busy0 !== 1'b0) begin errors++; $display("[TB] FAIL mid_clear_out got en=%h rout=%h alu=%h busy=%b exp 0 0 0 0", en0, rout0, alu0, busy0); end
    checks++; if (cnt0 !== 16'd0) begin errors++; $display("[TB] FAIL mid_clear_count got %0d exp 0", cnt0); end
    @(negedge clock);
    clear = 1'b0;
    @(negedge clock);
    checks++; if (busy0 !== 1'b0) begin errors++; $display("[TB] FAIL mid_idle got busy=%b exp 0", busy0); end
    start0 = 1'b1;
    @(negedge clock); start0 = 1'b0;
    cyc = 1;
    while (done0 !== 1'b1 && cyc < 20) begin
      @(negedge clock); cyc++;
    end
    checks++; if (cyc !== 6 || rin0 !== 16'h0004) begin errors++; $display("[TB] FAIL mid_rerun got cycles=%0d rin=%h exp 6 0004", cyc, rin0); end
    @(negedge clock);
    checks++; if (cnt0 !== 16'd1) begin errors++; $display("[TB] FAIL mid_rerun_count got %0d exp 1", cnt0); end
  endtask

  // Five back-to-back ADDs with start held on the CNT_W=2 build.
  task automatic test_back_to_back;
    logic [1:0] exp_cnt [5];
    int cyc;
    exp_cnt = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    ir = IR_ADD; mem_ready = 1'b1;
    start2 = 1'b1;
    for (int k = 0; k < 5; k++) begin
      cyc = 0;
      do begin
        @(negedge clock); cyc++;
      end while (done2 !== 1'b1 && cyc < 20);
      checks++; if (cyc !== 6 || done2 !== 1'b1) begin errors++; $display("[TB] FAIL b2b_latency_%0d got %0d done=%b exp 6 done=1", k, cyc, done2); end
      @(negedge clock);
      checks++; if (cnt2 !== exp_cnt[k] || busy2 !== 1'b0 || done2 !== 1'b0) begin errors++; $display("[TB] FAIL b2b_count_%0d got cnt=%0d busy=%b done=%b exp cnt=%0d busy=0 done=0", k, cnt2, busy2, done2, exp_cnt[k]); end
    end
    start2 = 1'b0;
    repeat (8) @(negedge clock);
    checks++; if (busy2 !== 1'b0 || cnt2 !== 2'd1) begin errors++; $display("[TB] FAIL b2b_final got busy=%b cnt=%0d exp 0 1", busy2, cnt2); end
  endtask

  initial begin
    test_reset;
    test_add;
    test_mem_wait;
    test_mul;
    test_illegal;
    test_reset_mid;
    test_back_to_back;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/rtype_control_sequencer.md
# rtype_control_sequencer

Hardwired multi-cycle control unit that drives the CPU datapath's control buses through the instruction fetch (T0–T2) and execute (T3–T6) steps for all register-to-register ALU instructions. It replaces per-instruction hand-written control with one parametrised FSM. It decodes opcode and register fields from the IR, inserts memory wait states, and handles the two-result (HI/LO) class used by mul and div. It sits between the IR/memory interface and the datapath enable inputs.

## Interface
- NREGS, 16: number of general registers; also the width of Rin and Rout. Must be ≤ 16.
- ALUOP_W, 4: ALU operation select width.
- CNT_W, 16: width of the retired-instruction counter.
- clock  in  1: system clock; all state changes on the rising edge.
- clear  in  1: reset, asynchronous and active-high.
- start  in  1: begin one instruction. Sampled only in IDLE.
- mem_ready  in  1: memory read data is valid on Mdatain this cycle.
- ir  in  32: current IR contents. Fields:
  - opcode = ir[31:27]
  - Ra = ir[26:23]
  - Rb = ir[22:19]
  - Rc = ir[18:15]
- PCout, MARin, IncPC, PCin, Read, MDRin, MDRout, IRin, Yin, Zlowin, Zhighin, Zlowout, Zhighout, LOin, HIin  out  1 each: datapath enables.
- Rin, Rout  out  NREGS: one-hot register write and read enables.
- ALUop  out  ALUOP_W: ALU operation select.
- busy  out  1: high in any state except IDLE.
- done  out  1: one-cycle pulse in the final execute step.
- illegal  out  1: one-cycle pulse on an undecodable instruction.
- instr_count  out  CNT_W: number of instructions retired with done.

## Operation
- States: IDLE, T0, T1, T2, T3, T4, T5, T6. Encoding is free.
- Outputs are Moore-style, decoded from the state and the ir fields. Every output not listed for a state is 0.
- IDLE: all enables 0. On start=1 go to T0; otherwise stay.
- T0: PCout, MARin, IncPC, Zlowin. Go to T1.
- T1: Zlowout, PCin, Read, MDRin.
  - Zlowout and PCin are asserted only in the first T1 cycle; the PC updates exactly once.
  - Read and MDRin are held every T1 cycle.
  - Go to T2 when mem_ready=1; otherwise stay in T1.
- T2: MDRout, IRin. Go to T3.
- T3 (decode): validate opcode and register indices.
  - Illegal if the opcode is not in the table below, or any used index (Ra, Rb, Rc) is ≥ NREGS. Ra is unused for mul/div.
  - If illegal: illegal=1, no other enable, next state IDLE.
  - Else: Rout[Rb]=1, Yin=1, next state T4.
- Opcode table:
  - 0x03 add, 0x04 sub, 0x05 and, 0x06 or, 0x07 shr, 0x08 shra, 0x09 shl, 0x0A ror, 0x0B rol: single class, ALUop = opcode[ALUOP_W-1:0].
  - 0x0F mul: dual class, ALUop = all-ones.
  - 0x10 div: dual class, ALUop = all-ones minus 1.
- T4: Rout[Rc], ALUop, Zlowin. For the dual class also Zhighin. Go to T5.
- T5:
  - Single class: Zlowout, Rin[Ra], done. Next state IDLE.
  - Dual class: Zlowout, LOin. Next state T6.
- T6 (dual class only): Zhighout, HIin, done. Next state IDLE.
- ALUop is held stable during T4 only; it is 0 in all other states.
- instr_count increments on the edge that leaves a done state. It wraps from 2^CNT_W−1 to 0. Illegal instructions do not count.
- start while busy is ignored; no queuing.

## Timing
- Reset: state IDLE, every output 0, instr_count 0. This takes effect immediately on clear=1, independent of clock, including mid-instruction. The first edge after clear falls is treated as IDLE.
- Latency from the edge that samples start to done, with mem_ready=1 in the first T1 cycle:
  - Single class: done during the 6th state cycle (T5).
  - Dual class: done during the 7th state cycle (T6).
- Each cycle of mem_ready=0 in T1 adds one cycle.
- Back-to-back instructions: start high during the done cycle is ignored because the state is not IDLE. The earliest next T0 is 2 cycles after done.
- ir must be stable from T3 through the final step. The sequencer does not register ir.
- Rin and Rout are at most one-hot; both are never nonzero in the same cycle.

## Test plan
- ADD R2,R5,R6:
  - Stimulus: ir=0x192B0000, start pulse, mem_ready=1.
  - Required: T3 Rout=0x0020 with Yin; T4 Rout=0x0040 with ALUop=3 and Zlowin; T5 Rin=0x0004 with Zlowout and done; instr_count=1.
- Memory wait:
  - Stimulus: same instruction, mem_ready=0 for 3 cycles in T1.
  - Required: T1 lasts 4 cycles; Read and MDRin high in all 4; PCin high only in the first; done 3 cycles later than in the ADD case.
- MUL R3,R4:
  - Stimulus: ir=0x781A0000.
  - Required: T4 ALUop=0xF with Zlowin and Zhighin; T5 LOin with Zlowout; T6 HIin with Zhighout and done; Rin=0 throughout.
- Illegal instruction:
  - Stimulus: opcode 0x1F (ir=0xF8000000); separately NREGS=8 with Ra=9.
  - Required: illegal pulse in T3; no Rout or Yin asserted; return to IDLE; done never asserted; instr_count unchanged.
- Reset mid-instruction:
  - Stimulus: assert clear between clock edges during T4.
  - Required: all outputs 0 before the next edge; IDLE afterward; instr_count=0; a new start executes normally.
- Counter wrap and busy:
  - Stimulus: CNT_W=2, five ADDs back to back; start held continuously.
  - Required: instr_count sequence 1,2,3,0,1; no state change from start while busy; exactly one done per instruction.
